// File: rtl/game_pkg.sv
// Shared constants for the tic-tac-toe sequencer: cell codes, FSM encodings
// and the table of the eight winning lines.
package game_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned CELL_W    = 2;
  localparam int unsigned BOARD_W   = NUM_CELLS * CELL_W;
  localparam int unsigned NUM_LINES = 8;
  localparam int unsigned SQ_W      = 4;
  localparam int unsigned CNT_W     = 4;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PLAY      = 2'd1;
  localparam logic [1:0] CHECK     = 2'd2;
  localparam logic [1:0] GAME_OVER = 2'd3;

  // Index 0 is the top row; order is rows, columns, main diagonal, anti-diagonal.
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] LINE_MASK = {
    9'h054, 9'h111,
    9'h124, 9'h092, 9'h049,
    9'h1C0, 9'h038, 9'h007
  };

  // Cell k is zero-based here (cell 1 of the board is k = 0).
  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] b,
                                                input logic [SQ_W-1:0]    k);
    return b[5'(k) * 5'd2 +: 2];
  endfunction

endpackage

// File: rtl/win_detect.sv
// Combinational line checker: reports whether the mover owns a full line and
// which line, preferring the lowest line index when several are complete.
module win_detect
  import game_pkg::*;
(
  input  logic [BOARD_W-1:0]   board,
  input  logic [CELL_W-1:0]    mover,
  output logic                 win,
  output logic [NUM_CELLS-1:0] line_mask
);

  logic hit;

  // Scan from the highest index down so the lowest complete line is kept last.
  always_comb begin
    win       = 1'b0;
    line_mask = '0;
    hit       = 1'b0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      hit = 1'b1;
      for (int j = 0; j < NUM_CELLS; j++) begin
        if (LINE_MASK[3'(i)][4'(j)] && (cell_at(board, 4'(j)) != mover)) begin
          hit = 1'b0;
        end
      end
      if (hit) begin
        win       = 1'b1;
        line_mask = LINE_MASK[3'(i)];
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Tic-tac-toe sequencer: owns the board, alternates X/O, detects win/draw and
// drives square highlight enables plus the global start_en for the draw stages.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned BLINK_W      = 6
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 start_btn,
  input  logic                 click_valid,
  input  logic [SQ_W-1:0]      click_square,
  input  logic [SQ_W-1:0]      hover_square,
  input  logic                 vsync_in,
  output logic                 start_en,
  output logic [NUM_CELLS-1:0] square_en,
  output logic [BOARD_W-1:0]   board,
  output logic                 turn,
  output logic                 click_ack,
  output logic                 click_rej,
  output logic                 game_over,
  output logic [CELL_W-1:0]    winner
);

  logic [1:0]           state_q, state_d;
  logic [BOARD_W-1:0]   board_d;
  logic                 turn_d;
  logic [CNT_W-1:0]     move_q, move_d;
  logic [CELL_W-1:0]    winner_d;
  logic [NUM_CELLS-1:0] mask_q, mask_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 vsync_q;
  logic                 vsync_rise;
  logic                 ack_d, rej_d;
  logic [NUM_CELLS-1:0] sq_d;
  logic [CELL_W-1:0]    mover;
  logic                 click_ok;
  logic [NUM_CELLS-1:0] empty_map;
  logic                 line_win;
  logic [NUM_CELLS-1:0] line_mask;

  assign mover      = turn ? CELL_O : CELL_X;
  assign vsync_rise = vsync_in & ~vsync_q;

  win_detect u_win_detect (
    .board     (board),
    .mover     (mover),
    .win       (line_win),
    .line_mask (line_mask)
  );

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d     = state_q;
    board_d     = board;
    turn_d      = turn;
    move_d      = move_q;
    winner_d    = winner;
    mask_d      = mask_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    ack_d       = 1'b0;
    rej_d       = 1'b0;
    sq_d        = '0;
    click_ok    = 1'b0;
    empty_map   = '0;

    for (int k = 0; k < NUM_CELLS; k++) begin
      empty_map[4'(k)] = (cell_at(board, 4'(k)) == CELL_EMPTY);
      if ((click_square == 4'(k + 1)) && empty_map[4'(k)]) click_ok = 1'b1;
    end

    if (start_btn) begin
      state_d  = PLAY;
      board_d  = '0;
      turn_d   = 1'b0;
      move_d   = '0;
      winner_d = CELL_EMPTY;
    end else begin
      case (state_q)
        PLAY: begin
          if (click_valid) begin
            if (click_ok) begin
              for (int k = 0; k < NUM_CELLS; k++) begin
                if (click_square == 4'(k + 1)) board_d[5'(2 * k) +: 2] = mover;
              end
              ack_d   = 1'b1;
              move_d  = move_q + 4'd1;
              state_d = CHECK;
            end else begin
              rej_d = 1'b1;
            end
          end
        end
        CHECK: begin
          if (line_win) begin
            state_d     = GAME_OVER;
            winner_d    = mover;
            mask_d      = line_mask;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end else if (move_q == CNT_W'(NUM_CELLS)) begin
            state_d     = GAME_OVER;
            winner_d    = CELL_EMPTY;
            blink_cnt_d = '0;
            phase_d     = 1'b1;
          end else begin
            turn_d  = ~turn;
            state_d = PLAY;
          end
        end
        GAME_OVER: begin
          if (vsync_rise) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
              blink_cnt_d = '0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
          end
        end
        default: ;
      endcase
    end

    // Highlight follows the current state, not the one being entered.
    case (state_q)
      PLAY: begin
        for (int k = 0; k < NUM_CELLS; k++) begin
          if ((hover_square == 4'(k + 1)) && empty_map[4'(k)]) sq_d[4'(k)] = 1'b1;
        end
      end
      GAME_OVER: begin
        if ((winner != CELL_EMPTY) && phase_q) sq_d = mask_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      board       <= '0;
      turn        <= 1'b0;
      move_q      <= '0;
      winner      <= CELL_EMPTY;
      mask_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      vsync_q     <= 1'b0;
      click_ack   <= 1'b0;
      click_rej   <= 1'b0;
      square_en   <= '0;
      start_en    <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      board       <= board_d;
      turn        <= turn_d;
      move_q      <= move_d;
      winner      <= winner_d;
      mask_q      <= mask_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      vsync_q     <= vsync_in;
      click_ack   <= ack_d;
      click_rej   <= rej_d;
      square_en   <= sq_d;
      start_en    <= (state_d != IDLE);
      game_over   <= (state_d == GAME_OVER);
    end
  end

endmodule
